// File: rtl/dwt_pkg.sv
// -----------------------------------------------------------------------------
// dwt_pkg
// Shared types and defaults for the DWT level scheduler slice.
//   state_t      : scheduler FSM states (IDLE, RUN, FLUSH, DONE)
//   LEVELS_MAX   : default number of decomposition levels / ce_lvl bits
//   FRAME_W_DEF  : default frame-length and sample-counter width
//   PHASES_DEF   : default polyphase branch count
//   FLUSH_DEF    : default zero-pad pseudo-samples per level-0 period
//   PH_W         : width of the phase index output
// -----------------------------------------------------------------------------
package dwt_pkg;

    // Enum literals carry an ST_ prefix so they cannot collide with the
    // FLUSH module parameter once the package is wildcard-imported.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LEVELS_MAX  = 3;
    localparam int FRAME_W_DEF = 16;
    localparam int PHASES_DEF  = 6;
    localparam int FLUSH_DEF   = 12;
    localparam int PH_W        = 3;

endpackage

// File: rtl/dwt_ce_gen.sv
// -----------------------------------------------------------------------------
// dwt_ce_gen
// Combinational map from the 0-based sample index of the sample being issued
// to the per-level clock-enable vector. Level j fires when the issued sample
// completes a group of 2^j level-0 samples and j is an active level.
// Ports:
//   s_i          : index of the sample issued this cycle
//   levels_cfg_i : number of active levels (1..LEVELS)
//   strobe_i     : a real or pseudo sample is issued this cycle
//   ce_o         : per-level enable vector for that sample
// -----------------------------------------------------------------------------
module dwt_ce_gen
    import dwt_pkg::*;
#(
    parameter int LEVELS  = LEVELS_MAX,
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic [FRAME_W-1:0] s_i,
    input  logic [2:0]         levels_cfg_i,
    input  logic               strobe_i,
    output logic [LEVELS-1:0]  ce_o
);

    logic [FRAME_W-1:0] s_next;

    // Counter wrap is harmless: only the low j bits of s+1 matter and 2^j
    // divides 2^FRAME_W.
    assign s_next = s_i + FRAME_W'(1);

    always_comb begin
        ce_o = '0;
        for (int j = 0; j < LEVELS; j++) begin
            ce_o[j] = strobe_i
                   && (j < int'(levels_cfg_i))
                   && ((s_next & ((FRAME_W'(1) << j) - FRAME_W'(1))) == '0);
        end
    end

endmodule

// File: rtl/dwt_level_sched.sv
// -----------------------------------------------------------------------------
// dwt_level_sched
// Single-clock scheduler for the multi-level DWT analysis chain. Generates
// per-level clock enables instead of divided clocks, accepts samples via a
// valid/ready handshake, tracks the polyphase branch and sequences one frame:
// RUN (real samples), FLUSH (zero-padded pseudo-samples), DONE.
//
// Handshake: in_ready is high exactly in RUN and depends only on state; a
// sample transfers on a rising edge where in_valid & in_ready are both high.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a frame (sampled only in IDLE)
//   abort        : abandon current frame, back to IDLE (highest priority)
//   frame_len    : samples per frame, latched on accepted start
//   levels_cfg   : active levels 1..LEVELS, latched on accepted start
//   in_valid     : upstream sample valid
//   in_ready     : sample accepted this cycle when in_valid is high
//   ce_lvl       : registered per-level clock enables
//   zero_pad     : current strobe is a flush (zero) sample
//   phase        : polyphase branch of the current level-0 strobe
//   busy         : high in RUN and FLUSH
//   done         : one-cycle frame-complete pulse
//   err_cfg      : one-cycle pulse for a rejected start
//   state_dbg    : current FSM state, for observation
// -----------------------------------------------------------------------------
module dwt_level_sched
    import dwt_pkg::*;
#(
    parameter int LEVELS  = LEVELS_MAX,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int PHASES  = PHASES_DEF,
    parameter int FLUSH   = FLUSH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FRAME_W-1:0] frame_len,
    input  logic [2:0]         levels_cfg,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [LEVELS-1:0]  ce_lvl,
    output logic               zero_pad,
    output logic [PH_W-1:0]    phase,
    output logic               busy,
    output logic               done,
    output logic               err_cfg,
    output logic [1:0]         state_dbg
);

    localparam int FLUSH_MAX = FLUSH << (LEVELS - 1);
    localparam int F_W       = $clog2(FLUSH_MAX + 1);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] s_q, s_d;
    logic [F_W-1:0]     f_q, f_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [2:0]         lv_q, lv_d;
    logic [FRAME_W-1:0] len_q, len_d;
    logic [LEVELS-1:0]  ce_q, ce_d;
    logic               zp_q, zp_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [LEVELS-1:0]  ce_next;
    logic               gen_strobe;
    logic [FRAME_W-1:0] len_mask;
    logic               cfg_ok;
    logic [F_W-1:0]     flush_total;
    logic [PH_W-1:0]    phase_inc;

    // A sample is issued on an accepted input in RUN, and every cycle in FLUSH.
    assign gen_strobe = ((state_q == ST_RUN) && in_valid) || (state_q == ST_FLUSH);

    dwt_ce_gen #(
        .LEVELS  (LEVELS),
        .FRAME_W (FRAME_W)
    ) u_ce_gen (
        .s_i          (s_q),
        .levels_cfg_i (lv_q),
        .strobe_i     (gen_strobe),
        .ce_o         (ce_next)
    );

    // frame_len must be a non-zero multiple of 2^levels_cfg so every level
    // sees whole decimation groups.
    assign len_mask = (FRAME_W'(1) << levels_cfg) - FRAME_W'(1);
    assign cfg_ok   = (levels_cfg != 3'd0)
                   && (int'(levels_cfg) <= LEVELS)
                   && (frame_len != '0)
                   && ((frame_len & len_mask) == '0);

    // Deeper decompositions need proportionally longer drains.
    assign flush_total = F_W'(FLUSH) << (lv_q - 3'd1);

    assign phase_inc = (phase_q == PH_W'(PHASES - 1)) ? '0 : phase_q + PH_W'(1);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        f_d     = f_q;
        lv_d    = lv_q;
        len_d   = len_q;
        ce_d    = '0;
        zp_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // phase names the branch of the strobe currently shown, so it moves
        // on once that strobe has been presented.
        phase_d = ce_q[0] ? phase_inc : phase_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        lv_d    = levels_cfg;
                        len_d   = frame_len;
                        s_d     = '0;
                        f_d     = '0;
                        phase_d = '0;
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    ce_d = ce_next;
                    s_d  = s_q + FRAME_W'(1);
                    if (s_q == len_q - FRAME_W'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                ce_d = ce_next;
                zp_d = 1'b1;
                s_d  = s_q + FRAME_W'(1);
                f_d  = f_q + F_W'(1);
                if (f_q == flush_total - F_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            ce_d    = '0;
            zp_d    = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            s_d     = '0;
            f_d     = '0;
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            f_q     <= '0;
            phase_q <= '0;
            lv_q    <= '0;
            len_q   <= '0;
            ce_q    <= '0;
            zp_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            f_q     <= f_d;
            phase_q <= phase_d;
            lv_q    <= lv_d;
            len_q   <= len_d;
            ce_q    <= ce_d;
            zp_q    <= zp_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign ce_lvl    = ce_q;
    assign zero_pad  = zp_q;
    assign phase     = phase_q;
    assign done      = done_q;
    assign err_cfg   = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dwt_level_sched.sv
module tb_dwt_level_sched;
    import dwt_pkg::*;

    localparam int L  = 3;
    localparam int FW = 16;
    localparam int PH = 6;
    localparam int FL = 12;
    localparam int W  = L + 1 + 3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [FW-1:0] frame_len;
    logic [2:0]    levels_cfg;
    logic          in_valid;
    logic          in_ready;
    logic [L-1:0]  ce_lvl;
    logic          zero_pad;
    logic [2:0]    phase;
    logic          busy;
    logic          done;
    logic          err_cfg;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    dwt_level_sched #(
        .LEVELS  (L),
        .FRAME_W (FW),
        .PHASES  (PH),
        .FLUSH   (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .frame_len  (frame_len),
        .levels_cfg (levels_cfg),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ce_lvl     (ce_lvl),
        .zero_pad   (zero_pad),
        .phase      (phase),
        .busy       (busy),
        .done       (done),
        .err_cfg    (err_cfg),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the k-th issued sample (real for k < len, pad otherwise)
    // enables level j when j < lv and 2^j divides k+1; its branch is k mod PH.
    task automatic build_model(input int len, input int lv);
        int total;
        logic [L-1:0] ce;
        total = len + (FL << (lv - 1));
        exp_q.delete();
        for (int k = 0; k < total; k++) begin
            ce = '0;
            for (int j = 0; j < L; j++) begin
                if (j < lv && ((k + 1) % (1 << j)) == 0) ce[j] = 1'b1;
            end
            exp_q.push_back({ce, 1'(k >= len), 3'(k % PH)});
        end
    endtask

    // ---------------- drivers ----------------
    // mode 0: in_valid held high; 1: pattern 1,0,0,...; 2: random.
    task automatic run_frame(input int len, input int lv, input int mode);
        int acc_cnt;
        int cyc;
        bit prev_acc;
        bit seen_done;
        bit v;
        logic [W-1:0] ev;
        acc_cnt   = 0;
        cyc       = 0;
        prev_acc  = 1'b0;
        seen_done = 1'b0;
        build_model(len, lv);
        start      = 1'b1;
        frame_len  = FW'(len);
        levels_cfg = 3'(lv);
        in_valid   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!seen_done && cyc < 4000) begin
            check("err_quiet", 32'(err_cfg), 0);
            if (acc_cnt < len) begin
                check("in_ready_run", 32'(in_ready), 1);
                check("busy_run", 32'(busy), 1);
            end else begin
                check("in_ready_low", 32'(in_ready), 0);
            end
            if (prev_acc) check("ce0_after_accept", 32'(ce_lvl[0]), 1);
            else if (acc_cnt < len) check("ce_gap", 32'(ce_lvl), 0);
            if (ce_lvl != '0) begin
                if (exp_q.size() == 0) begin
                    check("extra_strobe", 32'(ce_lvl), 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("strobe", 32'({ce_lvl, zero_pad, phase}), 32'(ev));
                end
            end else begin
                check("zp_without_ce", 32'(zero_pad), 0);
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_busy_low", 32'(busy), 0);
                check("model_drained", 32'(exp_q.size()), 0);
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            prev_acc = v && in_ready;
            if (prev_acc) acc_cnt++;
            // start and configuration churn must be ignored while busy
            start      = seen_done ? 1'b0 : 1'($urandom_range(0, 1));
            frame_len  = FW'($urandom);
            levels_cfg = 3'($urandom);
            @(negedge clk);
            cyc++;
        end
        check("frame_done_seen", 32'(seen_done), 1);
        check("done_one_cycle", 32'(done), 0);
        check("idle_after_done", 32'(state_dbg), 32'(ST_IDLE));
        in_valid = 1'b0;
    endtask

    typedef struct {
        int lv;
        int len;
        bit ok;
    } cfg_vec_t;

    cfg_vec_t cfg_tab[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cfg_tab[0]  = '{0, 8, 1'b0};
        cfg_tab[1]  = '{2, 6, 1'b0};
        cfg_tab[2]  = '{4, 16, 1'b0};
        cfg_tab[3]  = '{1, 0, 1'b0};
        cfg_tab[4]  = '{1, 1, 1'b0};
        cfg_tab[5]  = '{3, 8, 1'b1};
        cfg_tab[6]  = '{3, 12, 1'b0};
        cfg_tab[7]  = '{2, 4, 1'b1};
        cfg_tab[8]  = '{1, 2, 1'b1};
        cfg_tab[9]  = '{7, 128, 1'b0};
        cfg_tab[10] = '{3, 65528, 1'b1};

        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        frame_len  = '0;
        levels_cfg = '0;
        in_valid   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ce", 32'(ce_lvl), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_zp", 32'(zero_pad), 0);
        check("rst_phase", 32'(phase), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err_cfg), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // configuration acceptance table
        for (int i = 0; i < 11; i++) begin
            start      = 1'b1;
            levels_cfg = 3'(cfg_tab[i].lv);
            frame_len  = FW'(cfg_tab[i].len);
            @(negedge clk);
            start = 1'b0;
            check("cfg_err", 32'(err_cfg), 32'(!cfg_tab[i].ok));
            check("cfg_busy", 32'(busy), 32'(cfg_tab[i].ok));
            check("cfg_state", 32'(state_dbg), cfg_tab[i].ok ? 32'(ST_RUN) : 32'(ST_IDLE));
            @(negedge clk);
            check("cfg_err_pulse", 32'(err_cfg), 0);
            if (cfg_tab[i].ok) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("cfg_abort_busy", 32'(busy), 0);
                check("cfg_abort_state", 32'(state_dbg), 32'(ST_IDLE));
            end
        end

        // abort beats a bad start in IDLE: no err pulse
        start = 1'b1; abort = 1'b1; levels_cfg = 3'd0; frame_len = FW'(8);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_over_err", 32'(err_cfg), 0);

        // nominal frame, phase wrap, back-pressure
        run_frame(8, 2, 0);
        run_frame(14, 1, 0);
        run_frame(8, 1, 1);

        // abort mid-RUN after three samples
        start = 1'b1; levels_cfg = 3'd2; frame_len = FW'(8);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ce", 32'(ce_lvl), 0);
        check("abort_ready", 32'(in_ready), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_zp", 32'(zero_pad), 0);
        check("abort_phase", 32'(phase), 0);
        check("abort_done", 32'(done), 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 0);
        end
        run_frame(8, 2, 0);

        // asynchronous reset during FLUSH
        start = 1'b1; levels_cfg = 3'd1; frame_len = FW'(2);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 20 && !zero_pad; c++) @(negedge clk);
        check("reach_flush", 32'(zero_pad), 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_ce", 32'(ce_lvl), 0);
        check("arst_zp", 32'(zero_pad), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_phase", 32'(phase), 0);
        check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
        start = 1'b1; levels_cfg = 3'd1; frame_len = FW'(2);
        repeat (2) @(negedge clk);
        check("arst_start_ignored", 32'(busy), 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("arst_release_idle", 32'(state_dbg), 32'(ST_IDLE));

        // randomized frames
        repeat (6) begin
            int lv;
            int len;
            lv  = int'($urandom_range(1, 3));
            len = int'($urandom_range(1, 5)) << lv;
            run_frame(len, lv, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
